// File: rtl/x2xy_decoder.sv
// Binary-to-one-hot decoder with valid/ready on both sides and a 2-entry skid
// buffer. Codes outside the one-hot range are delivered as an all-zero word with err set.
module x2xy_decoder #(
  parameter int IN_WIDTH  = 3,
  parameter int OP_WIDTH  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  inputCODE,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_WIDTH-1:0]  Q,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] code_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

  typedef struct packed {
    logic [OP_WIDTH-1:0] onehot;
    logic                err;
  } entry_t;

  state_e               state_q, state_d;
  entry_t               head_q, head_d;
  entry_t               skid_q, skid_d;
  entry_t               dec;
  logic                 in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 accept;
  logic                 pop;

  // err stays set unless some output bit matches the code.
  always_comb begin
    dec.onehot = '0;
    dec.err    = 1'b1;
    for (int k = 0; k < OP_WIDTH; k++) begin
      if (int'(inputCODE) == k) begin
        dec.onehot[k] = 1'b1;
        dec.err       = 1'b0;
      end
    end
  end

  assign accept = in_valid & in_ready_q & en;
  assign pop    = out_valid & out_ready;

  // NOTE: every variable gets a default first so no path through the case leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d = ONE;
          head_d  = dec;
        end
      end
      ONE: begin
        if (accept && !pop) begin
          state_d = TWO;
          skid_d  = dec;
        end else if (pop && !accept) begin
          state_d = EMPTY;
        end else if (pop && accept) begin
          head_d = dec;
        end
      end
      TWO: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Ready is computed from the next occupancy, so it never depends on out_ready
  // within the same cycle.
  assign in_ready_d = en & (state_d != TWO);
  assign cnt_d      = (accept && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the two buffer entries are reset too, so no stale
  // word survives a reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign Q         = out_valid ? head_q.onehot : '0;
  assign err       = out_valid & head_q.err;
  assign code_cnt  = cnt_q;

endmodule

// File: tb/tb_x2xy_decoder.sv
// Directed bench for x2xy_decoder: instance A (8 outputs, 16-bit counter) and
// instance B (6 outputs, 2-bit counter), each tracked by its own expected-beat queue.
module tb_x2xy_decoder;

  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic       rst_a, en_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, err_a;
  logic [2:0] code_a;
  logic [7:0] q_a;
  logic [15:0] cnt_a;

  logic       rst_b, en_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, err_b;
  logic [2:0] code_b;
  logic [5:0] q_b;
  logic [1:0] cnt_b;

  logic [8:0] sb_a[$];
  logic [8:0] sb_b[$];
  logic [8:0] e_a, e_b;

  x2xy_decoder #(.IN_WIDTH(3), .OP_WIDTH(8), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .inputCODE(code_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .Q(q_a), .err(err_a), .code_cnt(cnt_a)
  );

  x2xy_decoder #(.IN_WIDTH(3), .OP_WIDTH(6), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .inputCODE(code_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .Q(q_b), .err(err_b), .code_cnt(cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: {err, one-hot} for a given output width.
  function automatic logic [8:0] model(input int code, input int op);
    if (code < op) return {1'b0, 8'(1 << code)};
    return {1'b1, 8'h00};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_a();
    int n = 0;
    while ((sb_a.size() != 0 || out_valid_a) && n < 20) begin
      step();
      n++;
    end
    check("drain_a_bound", 32'(n < 20), 32'd1);
  endtask

  task automatic drain_b();
    int n = 0;
    while ((sb_b.size() != 0 || out_valid_b) && n < 20) begin
      step();
      n++;
    end
    check("drain_b_bound", 32'(n < 20), 32'd1);
  endtask

  // Scoreboards: compare the head beat on every transfer, then record new accepts.
  always @(negedge clk) begin
    if (rst_a) begin
      if (out_valid_a && out_ready_a) begin
        if (sb_a.size() == 0) check("a_unexpected_beat", 32'(sb_a.size()), 32'd1);
        else begin
          e_a = sb_a.pop_front();
          check("a_q", 32'(q_a), 32'(e_a[7:0]));
          check("a_err", 32'(err_a), 32'(e_a[8]));
        end
      end else if (!out_valid_a) begin
        check("a_idle_zero", 32'({q_a, err_a}), 32'd0);
      end
      if (in_valid_a && in_ready_a && en_a) sb_a.push_back(model(int'(code_a), 8));
    end
  end

  always @(negedge clk) begin
    if (rst_b) begin
      if (out_valid_b && out_ready_b) begin
        if (sb_b.size() == 0) check("b_unexpected_beat", 32'(sb_b.size()), 32'd1);
        else begin
          e_b = sb_b.pop_front();
          check("b_q", 32'(q_b), 32'(e_b[7:0]));
          check("b_err", 32'(err_b), 32'(e_b[8]));
        end
      end else if (!out_valid_b) begin
        check("b_idle_zero", 32'({q_b, err_b}), 32'd0);
      end
      if (in_valid_b && in_ready_b && en_b) sb_b.push_back(model(int'(code_b), 6));
    end
  end

  initial begin
    rst_a = 1'b0; en_a = 1'b1; in_valid_a = 1'b1; code_a = 3'd3; out_ready_a = 1'b1;
    rst_b = 1'b0; en_b = 1'b1; in_valid_b = 1'b0; code_b = 3'd0; out_ready_b = 1'b1;

    // Reset held with a valid code offered.
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready_a), 32'd0);
    check("rst_out_valid", 32'(out_valid_a), 32'd0);
    check("rst_q", 32'(q_a), 32'd0);
    check("rst_cnt", 32'(cnt_a), 32'd0);
    in_valid_a = 1'b0;
    rst_a = 1'b1;
    check("release_no_edge_in_ready", 32'(in_ready_a), 32'd0);
    step();
    check("release_in_ready", 32'(in_ready_a), 32'd1);

    // Sweep all codes back-to-back with the sink always ready.
    for (int c = 0; c < 8; c++) begin
      code_a = 3'(c);
      in_valid_a = 1'b1;
      step();
      if (c == 0) begin
        check("latency_valid", 32'(out_valid_a), 32'd1);
        check("latency_q", 32'(q_a), 32'h01);
      end
      check("sweep_in_ready", 32'(in_ready_a), 32'd1);
    end
    in_valid_a = 1'b0;
    step();
    check("sweep_cnt", 32'(cnt_a), 32'd8);
    drain_a();

    // Backpressure: two accepts fill the buffer and stall the input.
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; code_a = 3'd5;
    step();
    code_a = 3'd2;
    step();
    in_valid_a = 1'b0;
    check("bp_in_ready_low", 32'(in_ready_a), 32'd0);
    check("bp_q_head", 32'(q_a), 32'h20);
    repeat (2) step();
    check("bp_q_stable", 32'(q_a), 32'h20);
    check("bp_valid_stable", 32'(out_valid_a), 32'd1);
    out_ready_a = 1'b1;
    step();
    check("bp_q_second", 32'(q_a), 32'h04);
    step();
    check("bp_empty", 32'(out_valid_a), 32'd0);
    check("bp_in_ready_back", 32'(in_ready_a), 32'd1);
    check("bp_cnt", 32'(cnt_a), 32'd10);

    // Enable low: no accepts, the buffered entry still drains.
    out_ready_a = 1'b0;
    in_valid_a = 1'b1; code_a = 3'd6;
    step();
    en_a = 1'b0; code_a = 3'd3;
    step();
    check("en_in_ready_low", 32'(in_ready_a), 32'd0);
    repeat (2) step();
    check("en_cnt_frozen", 32'(cnt_a), 32'd11);
    check("en_q_held", 32'(q_a), 32'h40);
    out_ready_a = 1'b1;
    step();
    check("en_drained", 32'(out_valid_a), 32'd0);
    check("en_cnt_after", 32'(cnt_a), 32'd11);
    in_valid_a = 1'b0; en_a = 1'b1;
    drain_a();

    // Narrow instance: out-of-range codes and counter saturation.
    rst_b = 1'b1;
    step();
    check("b_release_in_ready", 32'(in_ready_b), 32'd1);
    in_valid_b = 1'b1; code_b = 3'd7;
    step();
    check("oor_valid", 32'(out_valid_b), 32'd1);
    check("oor_q", 32'(q_b), 32'h00);
    check("oor_err", 32'(err_b), 32'd1);
    code_b = 3'd1;
    step();
    check("after_oor_q", 32'(q_b), 32'h02);
    check("after_oor_err", 32'(err_b), 32'd0);
    check("oor_counted", 32'(cnt_b), 32'd2);
    code_b = 3'd4; step();
    code_b = 3'd0; step();
    code_b = 3'd5; step();
    in_valid_b = 1'b0;
    step();
    check("sat_cnt", 32'(cnt_b), 32'd3);
    drain_b();

    // Fill to two entries, then reset mid-cycle.
    out_ready_b = 1'b0;
    in_valid_b = 1'b1; code_b = 3'd2; step();
    code_b = 3'd3; step();
    in_valid_b = 1'b0;
    check("two_valid", 32'(out_valid_b), 32'd1);
    check("two_in_ready", 32'(in_ready_b), 32'd0);
    check("two_q", 32'(q_b), 32'h04);
    #2;
    rst_b = 1'b0;
    sb_b.delete();
    #1;
    check("async_rst_valid", 32'(out_valid_b), 32'd0);
    check("async_rst_q", 32'(q_b), 32'd0);
    check("async_rst_cnt", 32'(cnt_b), 32'd0);
    check("async_rst_in_ready", 32'(in_ready_b), 32'd0);
    step();
    rst_b = 1'b1;
    out_ready_b = 1'b1;
    step();
    check("post_rst_no_beat", 32'(out_valid_b), 32'd0);
    step();
    check("post_rst_no_beat2", 32'(out_valid_b), 32'd0);
    check("post_rst_in_ready", 32'(in_ready_b), 32'd1);
    check("sb_a_empty", 32'(sb_a.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
